// File: rtl/sw_job_scheduler.sv
// sw_job_scheduler: queues scoring jobs, sequences them onto one SmithWaterman core and reduces its results
module sw_job_scheduler #(
  parameter int MATCH_BIT     = 4,
  parameter int CALC_BIT      = 12,
  parameter int MAX_T_NUM_BIT = 8,
  parameter int TAG_BIT       = 4,
  parameter int JOB_DEPTH     = 4,
  parameter int TMO_BIT       = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [MATCH_BIT-1:0]     job_match_i,
  input  logic [MATCH_BIT-1:0]     job_mismatch_i,
  input  logic [MATCH_BIT-1:0]     job_alpha_i,
  input  logic [MATCH_BIT-1:0]     job_beta_i,
  input  logic [TAG_BIT-1:0]       job_tag_i,
  input  logic [TMO_BIT-1:0]       timeout_cycles_i,
  output logic                     sw_start_o,
  output logic [MATCH_BIT-1:0]     sw_match_o,
  output logic [MATCH_BIT-1:0]     sw_mismatch_o,
  output logic [MATCH_BIT-1:0]     sw_alpha_o,
  output logic [MATCH_BIT-1:0]     sw_beta_o,
  input  logic                     sw_busy_i,
  input  logic                     sw_valid_i,
  input  logic [CALC_BIT-1:0]      sw_max_result_i,
  input  logic [MAX_T_NUM_BIT-1:0] sw_match_idx_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [TAG_BIT-1:0]       res_tag_o,
  output logic [CALC_BIT-1:0]      res_score_o,
  output logic [MAX_T_NUM_BIT-1:0] res_idx_o,
  output logic                     res_timeout_o,
  output logic                     idle_o
);
  localparam int PW = $clog2(JOB_DEPTH);
  localparam int JW = 4*MATCH_BIT + TAG_BIT;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, RUN, SETTLE, REPORT, RECOVER} state_t;
  state_t state;
  logic [JW-1:0] mem [JOB_DEPTH];
  logic [JW-1:0] job;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic [TMO_BIT-1:0] tmo_cnt, tmo_nxt;
  logic [1:0] wait_cnt;
  logic [CALC_BIT-1:0] best;
  logic [MAX_T_NUM_BIT-1:0] idx;
  logic push, pop, better, hit;
  assign job_ready_o = count != (PW+1)'(JOB_DEPTH);
  assign push = job_valid_i && job_ready_o;
  assign pop = state == IDLE && count != '0;
  assign {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o, res_tag_o} = job;
  assign res_score_o = best;
  assign res_idx_o = idx;
  assign idle_o = state == IDLE && count == '0;
  assign better = sw_valid_i && sw_max_result_i > best;
  assign tmo_nxt = tmo_cnt + 1'b1;
  assign hit = timeout_cycles_i != '0 && tmo_nxt == timeout_cycles_i;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {job_match_i, job_mismatch_i, job_alpha_i, job_beta_i, job_tag_i};
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      job <= '0;
      sw_start_o <= 1'b0;
      res_valid_o <= 1'b0;
      res_timeout_o <= 1'b0;
      best <= '0;
      idx <= '0;
      tmo_cnt <= '0;
      wait_cnt <= '0;
    end else begin
      if ((state == RUN || state == SETTLE) && better) begin
        best <= sw_max_result_i;
        idx <= sw_match_idx_i;
      end
      case (state)
        IDLE: if (pop) begin
          job <= mem[rd_ptr];
          state <= LOAD;
        end
        LOAD: begin
          sw_start_o <= 1'b1;
          state <= START;
        end
        START: begin
          sw_start_o <= 1'b0;
          best <= '0;
          idx <= '0;
          tmo_cnt <= '0;
          wait_cnt <= '0;
          res_timeout_o <= 1'b0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (sw_busy_i) state <= RUN;
          else if (wait_cnt == 2'd3) begin
            res_valid_o <= 1'b1;
            res_timeout_o <= 1'b1;
            state <= REPORT;
          end else wait_cnt <= wait_cnt + 2'd1;
        RUN: begin
          tmo_cnt <= tmo_nxt;
          if (hit) begin
            res_valid_o <= 1'b1;
            res_timeout_o <= 1'b1;
            state <= REPORT;
          end else if (!sw_busy_i) begin
            wait_cnt <= '0;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_cnt == 2'd1) begin
            res_valid_o <= 1'b1;
            state <= REPORT;
          end
        end
        REPORT: if (res_ready_i) begin
          res_valid_o <= 1'b0;
          state <= res_timeout_o ? RECOVER : IDLE;
        end
        RECOVER: if (!sw_busy_i) state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_sw_job_scheduler.sv
// tb_sw_job_scheduler: directed table-driven bench with a behavioural core model
module tb_sw_job_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic job_valid_i = 1'b0, job_ready_o;
  logic [3:0] job_match_i = '0, job_mismatch_i = '0, job_alpha_i = '0, job_beta_i = '0, job_tag_i = '0;
  logic [19:0] timeout_cycles_i = '0;
  logic sw_start_o;
  logic [3:0] sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o;
  logic sw_busy_i = 1'b0, sw_valid_i = 1'b0;
  logic [11:0] sw_max_result_i = '0;
  logic [7:0] sw_match_idx_i = '0;
  logic res_valid_o, res_ready_i = 1'b0;
  logic [3:0] res_tag_o;
  logic [11:0] res_score_o;
  logic [7:0] res_idx_o;
  logic res_timeout_o, idle_o;
  int checks = 0, failures = 0, start_cnt = 0;
  typedef struct {
    logic [3:0] m, mis, a, b, tag;
    int blen, n;
    logic [3:0][11:0] sc;
    logic [3:0][7:0] ix;
    logic tv;
    logic [11:0] tsc, es;
    logic [7:0] tix, ei;
  } vec_t;
  vec_t v [8];
  sw_job_scheduler dut (
    .clk(clk), .rst(rst), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_match_i(job_match_i), .job_mismatch_i(job_mismatch_i), .job_alpha_i(job_alpha_i),
    .job_beta_i(job_beta_i), .job_tag_i(job_tag_i), .timeout_cycles_i(timeout_cycles_i),
    .sw_start_o(sw_start_o), .sw_match_o(sw_match_o), .sw_mismatch_o(sw_mismatch_o),
    .sw_alpha_o(sw_alpha_o), .sw_beta_o(sw_beta_o), .sw_busy_i(sw_busy_i), .sw_valid_i(sw_valid_i),
    .sw_max_result_i(sw_max_result_i), .sw_match_idx_i(sw_match_idx_i), .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i), .res_tag_o(res_tag_o), .res_score_o(res_score_o), .res_idx_o(res_idx_o),
    .res_timeout_o(res_timeout_o), .idle_o(idle_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (sw_start_o) start_cnt++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input int m, mis, a, b, tag, blen, n, s0, i0, s1, i1, s2, i2,
                              input int tv, ts, ti, es, ei);
    vec_t r;
    r.m = 4'(m); r.mis = 4'(mis); r.a = 4'(a); r.b = 4'(b); r.tag = 4'(tag);
    r.blen = blen; r.n = n;
    r.sc = '0; r.ix = '0;
    r.sc[0] = 12'(s0); r.ix[0] = 8'(i0);
    r.sc[1] = 12'(s1); r.ix[1] = 8'(i1);
    r.sc[2] = 12'(s2); r.ix[2] = 8'(i2);
    r.tv = tv[0]; r.tsc = 12'(ts); r.tix = 8'(ti);
    r.es = 12'(es); r.ei = 8'(ei);
    return r;
  endfunction
  task automatic push_job(input vec_t j);
    int t = 0;
    job_valid_i = 1'b1;
    {job_match_i, job_mismatch_i, job_alpha_i, job_beta_i, job_tag_i} = {j.m, j.mis, j.a, j.b, j.tag};
    while (!job_ready_o && t < 200) begin tick(); t++; end
    chk("push_ready", job_ready_o, 1);
    tick();
    job_valid_i = 1'b0;
  endtask
  task automatic wait_start;
    int t = 0;
    while (!sw_start_o && t < 30) begin tick(); t++; end
    chk("start_seen", sw_start_o, 1);
  endtask
  task automatic wait_res;
    int t = 0;
    while (!res_valid_o && t < 30) begin tick(); t++; end
    chk("res_seen", res_valid_o, 1);
  endtask
  task automatic serve(input vec_t j);
    int s0 = start_cnt;
    wait_start();
    chk("params", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, {j.m, j.mis, j.a, j.b});
    for (int i = 0; i < j.blen; i++) begin
      sw_busy_i = 1'b1;
      sw_valid_i = i >= 2 && i - 2 < j.n;
      sw_max_result_i = sw_valid_i ? j.sc[i-2] : 12'h0;
      sw_match_idx_i = sw_valid_i ? j.ix[i-2] : 8'h0;
      tick();
      if (i == 0) chk("start_width", sw_start_o, 0);
    end
    sw_busy_i = 1'b0;
    sw_valid_i = j.tv;
    sw_max_result_i = j.tsc;
    sw_match_idx_i = j.tix;
    tick();
    sw_valid_i = 1'b0;
    wait_res();
    chk("res_tag", res_tag_o, j.tag);
    chk("res_score", res_score_o, j.es);
    chk("res_idx", res_idx_o, j.ei);
    chk("res_timeout", res_timeout_o, 0);
    chk("params_held", {sw_match_o, sw_mismatch_o, sw_alpha_o, sw_beta_o}, {j.m, j.mis, j.a, j.b});
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("res_cleared", res_valid_o, 0);
    chk("one_start", start_cnt - s0, 1);
  endtask
  initial begin
    vec_t q, r;
    int n, s;
    v[0] = mk(2, 1, 3, 1, 5, 10, 3, 3, 10, 9, 20, 7, 30, 0, 0, 0, 9, 20);
    v[1] = mk(1, 2, 3, 4, 3, 6, 2, 6, 3, 6, 4, 0, 0, 0, 0, 0, 6, 3);
    v[2] = mk(15, 15, 15, 15, 4, 6, 3, 6, 3, 6, 4, 8, 5, 0, 0, 0, 8, 5);
    v[3] = mk(0, 0, 0, 0, 15, 5, 2, 4095, 1, 5, 2, 0, 0, 0, 0, 0, 4095, 1);
    v[4] = mk(3, 3, 3, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[5] = mk(4, 5, 6, 7, 7, 3, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v[6] = mk(8, 9, 10, 11, 9, 4, 1, 4, 1, 0, 0, 0, 0, 1, 11, 9, 11, 9);
    v[7] = mk(5, 4, 3, 2, 10, 5, 2, 200, 100, 100, 50, 0, 0, 1, 150, 60, 200, 100);
    repeat (3) tick();
    chk("rst_ready", job_ready_o, 1);
    chk("rst_idle", idle_o, 1);
    chk("rst_outs", {sw_start_o, res_valid_o, res_timeout_o, sw_match_o, res_tag_o, res_score_o, res_idx_o}, 0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      push_job(v[i]);
      serve(v[i]);
    end
    // five queued jobs: first one occupies the core while the FIFO fills
    q = mk(1, 1, 1, 1, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_job(q);
    wait_start();
    sw_busy_i = 1'b1;
    for (int k = 1; k <= 4; k++) push_job(mk(k, k, k, k, k, 3, 1, 10*k, k, 0, 0, 0, 0, 0, 0, 0, 10*k, k));
    chk("fifo_full", job_ready_o, 0);
    sw_busy_i = 1'b0;
    wait_res();
    chk("q_tag", res_tag_o, 14);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) serve(mk(k, k, k, k, k, 3, 1, 10*k, k, 0, 0, 0, 0, 0, 0, 0, 10*k, k));
    chk("fifo_drained", {job_ready_o, idle_o}, 2'b11);
    // RUN timeout while the core stays busy, second job must wait for busy to fall
    timeout_cycles_i = 20'd20;
    q = mk(6, 6, 6, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r = mk(2, 3, 4, 5, 8, 4, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 5, 2);
    push_job(q);
    push_job(r);
    wait_start();
    sw_busy_i = 1'b1;
    n = 0;
    while (!res_valid_o && n < 60) begin tick(); n++; end
    chk("tmo_cycle", n, 22);
    chk("tmo_flag", res_timeout_o, 1);
    chk("tmo_tag", res_tag_o, 6);
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    timeout_cycles_i = '0;
    s = start_cnt;
    repeat (27) tick();
    chk("no_start_busy", start_cnt - s, 0);
    sw_busy_i = 1'b0;
    serve(r);
    // start lost: busy never rises, consumer stalls
    q = mk(7, 7, 7, 7, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    push_job(q);
    wait_start();
    n = 0;
    while (!res_valid_o && n < 20) begin tick(); n++; end
    chk("lost_cycle", n, 5);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", {res_valid_o, res_timeout_o, res_tag_o, res_score_o}, {1'b1, 1'b1, 4'd12, 12'd0});
    end
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    chk("lost_cleared", res_valid_o, 0);
    repeat (2) tick();
    chk("lost_idle", idle_o, 1);
    // reset mid-RUN with jobs queued
    push_job(mk(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    wait_start();
    sw_busy_i = 1'b1;
    push_job(mk(2, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push_job(mk(3, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    chk("run_not_idle", idle_o, 0);
    s = start_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {idle_o, job_ready_o, sw_start_o, res_valid_o}, 4'b1100);
    repeat (5) tick();
    sw_busy_i = 1'b0;
    repeat (10) tick();
    chk("mid_rst_quiet", {idle_o, 28'(start_cnt - s)}, {1'b1, 28'd0});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
